// File: rtl/day_of_week_calc.sv
// Bus-mapped Gregorian day-of-week coprocessor: bit-serial divide-by-100, date check, bit-serial mod 7.
// Define DOW_IRQ_EN to build the interrupt enable bit and the registered irq output.
module day_of_week_calc #(
    parameter int DATA_W   = 16,
    parameter int YEAR_W   = 14,
    parameter int MIN_YEAR = 1583,
    parameter int MAX_YEAR = 9999
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    input  logic              read,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);

    localparam int                S_W      = YEAR_W + 1;
    localparam int                CNT_W    = $clog2(YEAR_W + 2);
    localparam logic [YEAR_W-1:0] MIN_Y    = YEAR_W'(MIN_YEAR);
    localparam logic [YEAR_W-1:0] MAX_Y    = YEAR_W'(MAX_YEAR);
    localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(YEAR_W - 1);
    localparam logic [CNT_W-1:0]  MOD_LAST = CNT_W'(YEAR_W);

    typedef enum logic [1:0] {IDLE, DIV, CHECK, MOD} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [YEAR_W-1:0] year_q, year_d;
    logic [3:0]        month_q, month_d;
    logic [4:0]        date_q, date_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [2:0]        result_q, result_d;
    logic [YEAR_W-1:0] div_q, div_d;
    logic [6:0]        rem_q, rem_d;
    logic [S_W-1:0]    s_q, s_d;

    logic              busy, start, irq_en_rd;
    logic [7:0]        div_t;
    logic [3:0]        mod_t;
    logic [2:0]        mod_r;
    logic              early, leap, valid;
    logic [4:0]        dim;
    logic [YEAR_W-1:0] yp, qp;
    logic [S_W-1:0]    s_calc;
    logic              unused_wd;

    assign unused_wd = ^writedata;
    assign busy      = (state_q != IDLE);
    assign start     = write && (address == 3'd3) && writedata[0] && !busy;

    function automatic logic [2:0] t_off(input logic [3:0] m);
        case (m)
            4'd2, 4'd6:  t_off = 3'd3;
            4'd3, 4'd11: t_off = 3'd2;
            4'd4, 4'd7:  t_off = 3'd5;
            4'd8:        t_off = 3'd1;
            4'd9, 4'd12: t_off = 3'd4;
            4'd10:       t_off = 3'd6;
            default:     t_off = 3'd0;
        endcase
    endfunction

    always_comb begin
        div_t = {rem_q, div_q[YEAR_W-1]};
        mod_t = {rem_q[2:0], s_q[S_W-1]};
        mod_r = (mod_t >= 4'd7) ? 3'(mod_t - 4'd7) : mod_t[2:0];

        // In CHECK, div_q holds Y/100 and rem_q holds Y%100
        early = (month_q < 4'd3);
        leap  = (year_q[1:0] == 2'b00) && ((rem_q != '0) || (div_q[1:0] == 2'b00));
        case (month_q)
            4'd2:                      dim = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   dim = 5'd30;
            default:                   dim = 5'd31;
        endcase
        valid = (year_q >= MIN_Y) && (year_q <= MAX_Y) &&
                (month_q >= 4'd1) && (month_q <= 4'd12) &&
                (date_q != '0) && (date_q <= dim);
        yp     = early ? (year_q - YEAR_W'(1)) : year_q;
        qp     = div_q - YEAR_W'(early && (rem_q == '0));
        s_calc = S_W'(yp) + S_W'(yp >> 2) - S_W'(qp) + S_W'(qp >> 2) +
                 S_W'(t_off(month_q)) + S_W'(date_q);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        year_d   = year_q;
        month_d  = month_q;
        date_d   = date_q;
        done_d   = done_q;
        error_d  = error_q;
        result_d = result_q;
        div_d    = div_q;
        rem_d    = rem_q;
        s_d      = s_q;

        if (write) begin
            case (address)
                3'd0: if (!busy) year_d  = writedata[YEAR_W-1:0];
                3'd1: if (!busy) month_d = writedata[3:0];
                3'd2: if (!busy) date_d  = writedata[4:0];
                3'd3: if (writedata[2]) done_d = 1'b0;
                default: ;
            endcase
        end

        // FSM assignments follow the bus writes so completion overrides a same-cycle W1C
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DIV;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    div_d   = year_q;
                    rem_d   = '0;
                end
            end
            DIV: begin
                if (div_t >= 8'd100) begin
                    rem_d = 7'(div_t - 8'd100);
                    div_d = {div_q[YEAR_W-2:0], 1'b1};
                end else begin
                    rem_d = div_t[6:0];
                    div_d = {div_q[YEAR_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == DIV_LAST) state_d = CHECK;
            end
            CHECK: begin
                if (!valid) begin
                    result_d = 3'd7;
                    error_d  = 1'b1;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    s_d     = s_calc;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = MOD;
                end
            end
            MOD: begin
                rem_d = {4'b0000, mod_r};
                s_d   = s_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == MOD_LAST) begin
                    result_d = mod_r;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            year_q   <= '0;
            month_q  <= '0;
            date_q   <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            result_q <= '0;
            div_q    <= '0;
            rem_q    <= '0;
            s_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            year_q   <= year_d;
            month_q  <= month_d;
            date_q   <= date_d;
            done_q   <= done_d;
            error_q  <= error_d;
            result_q <= result_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            s_q      <= s_d;
        end
    end

`ifdef DOW_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q;

    always_comb begin
        irq_en_d = irq_en_q;
        if (write && (address == 3'd3)) irq_en_d = writedata[1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= done_q & irq_en_q;
        end
    end

    assign irq       = irq_q;
    assign irq_en_rd = irq_en_q;
`else
    assign irq       = 1'b0;
    assign irq_en_rd = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        if (read) begin
            case (address)
                3'd0:    readdata = DATA_W'(year_q);
                3'd1:    readdata = DATA_W'(month_q);
                3'd2:    readdata = DATA_W'(date_q);
                3'd3:    readdata = DATA_W'({error_q, done_q, irq_en_rd, busy});
                3'd4:    readdata = DATA_W'(result_q);
                default: readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_day_of_week_calc.sv
// Self-checking bench for day_of_week_calc against a Zeller-congruence calendar model.
module tb_day_of_week_calc;

    localparam int YEAR_W  = 14;
    localparam int LAT_OK  = 2 * YEAR_W + 2;
    localparam int LAT_BAD = YEAR_W + 1;
    localparam int BOUND   = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        write;
    logic [15:0] writedata;
    logic        read;
    logic [15:0] readdata;
    logic        irq;

    int errors = 0;
    int checks = 0;

    int dir_y[10] = '{2024, 2023, 1900, 2000, 2000, 1582, 9999, 2024, 2024, 2024};
    int dir_m[10] = '{2,    2,    2,    1,    2,    6,    12,   0,    13,   5};
    int dir_d[10] = '{29,   29,   29,   1,    29,   15,   31,   10,   10,   0};
    int dir_e[10] = '{4,    7,    7,    6,    2,    7,    5,    7,    7,    7};

    always #5 clk = ~clk;

    day_of_week_calc #(
        .DATA_W   (16),
        .YEAR_W   (YEAR_W),
        .MIN_YEAR (1583),
        .MAX_YEAR (9999)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .read      (read),
        .readdata  (readdata),
        .irq       (irq)
    );

    // Zeller's congruence (h: 0=Saturday), remapped to 0=Sunday; 7 for invalid dates
    function automatic int ref_dow(input int y, input int m, input int d);
        int  mdays[13];
        bit  leap;
        int  lim, yy, mm, k, j, h;
        mdays = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        leap  = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
        if (y < 1583 || y > 9999 || m < 1 || m > 12) return 7;
        lim = (m == 2 && leap) ? 29 : mdays[m];
        if (d < 1 || d > lim) return 7;
        yy = y;
        mm = m;
        if (m < 3) begin
            mm = m + 12;
            yy = y - 1;
        end
        k = yy % 100;
        j = yy / 100;
        h = (d + (13 * (mm + 1)) / 5 + k + k / 4 + j / 4 + 5 * j) % 7;
        return (h + 6) % 7;
    endfunction

    task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(posedge clk); #1;
        write     = 1'b0;
        writedata = '0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [15:0] v);
        address = a;
        read    = 1'b1;
        #1;
        v       = readdata;
        read    = 1'b0;
    endtask

    task automatic wait_idle(output int cycles, output logic ok);
        logic [15:0] c;
        cycles = 0;
        bus_rd(3'd3, c);
        while (c[0] && cycles < BOUND) begin
            @(posedge clk); #1;
            cycles++;
            bus_rd(3'd3, c);
        end
        ok = !c[0];
    endtask

    task automatic run_date(input int y, input int m, input int d, input logic en,
                            output logic [15:0] res, output logic [15:0] ctrl,
                            output int cycles, output logic ok);
        bus_wr(3'd0, 16'(y));
        bus_wr(3'd1, 16'(m));
        bus_wr(3'd2, 16'(d));
        bus_wr(3'd3, {14'd0, en, 1'b1});
        wait_idle(cycles, ok);
        bus_rd(3'd4, res);
        bus_rd(3'd3, ctrl);
    endtask

    task automatic test_reset();
        logic [15:0] v;
        for (int a = 0; a < 8; a++) begin
            bus_rd(3'(a), v);
            checks++;
            if (v !== 16'd0) begin
                errors++;
                $display("FAIL reset_read[%0d]: got %0h, want 0", a, v);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b, want 0", irq);
        end
    endtask

    task automatic test_regs();
        logic [15:0] v;
        bus_wr(3'd0, 16'hFFFF);
        bus_rd(3'd0, v);
        checks++; if (v !== 16'h3FFF) begin errors++; $display("FAIL year_mask: got %0h, want 3fff", v); end
        bus_wr(3'd1, 16'hFFFF);
        bus_rd(3'd1, v);
        checks++; if (v !== 16'h000F) begin errors++; $display("FAIL month_mask: got %0h, want f", v); end
        bus_wr(3'd2, 16'hFFFF);
        bus_rd(3'd2, v);
        checks++; if (v !== 16'h001F) begin errors++; $display("FAIL date_mask: got %0h, want 1f", v); end
        address = 3'd0;
        read    = 1'b0;
        #1;
        checks++; if (readdata !== 16'd0) begin errors++; $display("FAIL read_low: got %0h, want 0", readdata); end
        for (int a = 5; a < 8; a++) begin
            bus_rd(3'(a), v);
            checks++; if (v !== 16'd0) begin errors++; $display("FAIL unmapped[%0d]: got %0h, want 0", a, v); end
        end
        bus_wr(3'd3, 16'h0002);
        bus_rd(3'd3, v);
`ifdef DOW_IRQ_EN
        checks++; if (v !== 16'h0002) begin errors++; $display("FAIL ctrl_irqen: got %0h, want 2", v); end
`else
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL ctrl_irqen: got %0h, want 0", v); end
`endif
        bus_wr(3'd3, 16'h0000);
    endtask

    task automatic test_directed();
        logic [15:0] res, ctrl;
        int          cyc;
        logic        ok;
        for (int i = 0; i < 10; i++) begin
            run_date(dir_y[i], dir_m[i], dir_d[i], 1'b0, res, ctrl, cyc, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL dir_timeout[%0d]: busy after %0d cycles", i, cyc); end
            checks++;
            if (res !== 16'(dir_e[i])) begin
                errors++;
                $display("FAIL dir_result[%0d] %0d-%0d-%0d: got %0d, want %0d", i, dir_y[i], dir_m[i], dir_d[i], res, dir_e[i]);
            end
            checks++;
            if (ctrl !== ((dir_e[i] == 7) ? 16'h000C : 16'h0004)) begin
                errors++;
                $display("FAIL dir_ctrl[%0d]: got %0h, want %0h", i, ctrl, (dir_e[i] == 7) ? 16'h000C : 16'h0004);
            end
            checks++;
            if (cyc != ((dir_e[i] == 7) ? LAT_BAD : LAT_OK)) begin
                errors++;
                $display("FAIL dir_latency[%0d]: got %0d, want %0d", i, cyc, (dir_e[i] == 7) ? LAT_BAD : LAT_OK);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] res, ctrl;
        int          cyc, y, m, d, exp_r;
        logic        ok;
        for (int i = 0; i < 40; i++) begin
            y = $urandom_range(1400, 10300);
            m = $urandom_range(0, 13);
            d = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 28) : $urandom_range(0, 31);
            exp_r = ref_dow(y, m, d);
            run_date(y, m, d, 1'b0, res, ctrl, cyc, ok);
            checks++;
            if (!ok || res !== 16'(exp_r)) begin
                errors++;
                $display("FAIL rand_result %0d-%0d-%0d: got %0d, want %0d", y, m, d, res, exp_r);
            end
            checks++;
            if (ctrl[3] !== (exp_r == 7) || ctrl[2] !== 1'b1) begin
                errors++;
                $display("FAIL rand_flags %0d-%0d-%0d: got ctrl %0h, want error=%0d done=1", y, m, d, ctrl, exp_r == 7);
            end
            checks++;
            if (cyc != ((exp_r == 7) ? LAT_BAD : LAT_OK)) begin
                errors++;
                $display("FAIL rand_latency %0d-%0d-%0d: got %0d, want %0d", y, m, d, cyc, (exp_r == 7) ? LAT_BAD : LAT_OK);
            end
        end
    endtask

    task automatic test_busy_protect();
        logic [15:0] v;
        int          cyc;
        logic        ok;
        bus_wr(3'd0, 16'd2024);
        bus_wr(3'd1, 16'd2);
        bus_wr(3'd2, 16'd29);
        bus_wr(3'd3, 16'h0001);
        repeat (3) begin @(posedge clk); #1; end
        bus_wr(3'd0, 16'd1999);
        bus_wr(3'd3, 16'h0001);
        wait_idle(cyc, ok);
        checks++;
        if (!ok || cyc + 5 != LAT_OK) begin
            errors++;
            $display("FAIL busy_latency: got %0d, want %0d", cyc + 5, LAT_OK);
        end
        bus_rd(3'd4, v);
        checks++; if (v !== 16'(ref_dow(2024, 2, 29))) begin errors++; $display("FAIL busy_result: got %0d, want %0d", v, ref_dow(2024, 2, 29)); end
        bus_rd(3'd0, v);
        checks++; if (v !== 16'd2024) begin errors++; $display("FAIL busy_year: got %0d, want 2024", v); end
    endtask

    task automatic test_w1c();
        logic [15:0] v;
        int          cyc;
        logic        ok;
        bus_wr(3'd3, 16'h0004);
        bus_rd(3'd3, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL w1c_done: got %0h, want 0", v); end
        bus_rd(3'd4, v);
        checks++; if (v !== 16'd4) begin errors++; $display("FAIL w1c_hold: got %0d, want 4", v); end
        bus_wr(3'd3, 16'h0005);
        bus_rd(3'd3, v);
        checks++; if (v !== 16'h0001) begin errors++; $display("FAIL start_w1c: got %0h, want 1", v); end
        wait_idle(cyc, ok);
        bus_wr(3'd3, 16'h0004);
        bus_wr(3'd3, 16'h0001);
        repeat (LAT_OK - 1) begin @(posedge clk); #1; end
        bus_wr(3'd3, 16'h0004);
        bus_rd(3'd3, v);
        checks++; if (v !== 16'h0004) begin errors++; $display("FAIL done_vs_w1c: got %0h, want 4", v); end
    endtask

    task automatic test_reset_midop();
        logic [15:0] v, res, ctrl;
        int          cyc;
        logic        ok;
        bus_wr(3'd0, 16'd2000);
        bus_wr(3'd1, 16'd1);
        bus_wr(3'd2, 16'd1);
        bus_wr(3'd3, 16'h0003);
        repeat (10) begin @(posedge clk); #1; end
        #1 reset = 1'b1;
        #1;
        for (int a = 0; a < 5; a++) begin
            bus_rd(3'(a), v);
            checks++; if (v !== 16'd0) begin errors++; $display("FAIL midreset_read[%0d]: got %0h, want 0", a, v); end
        end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b, want 0", irq); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_date(2000, 2, 29, 1'b0, res, ctrl, cyc, ok);
        checks++;
        if (!ok || res !== 16'(ref_dow(2000, 2, 29)) || cyc != LAT_OK) begin
            errors++;
            $display("FAIL post_reset: got %0d in %0d cycles, want %0d in %0d", res, cyc, ref_dow(2000, 2, 29), LAT_OK);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] res, ctrl;
        int          cyc, y, m, d;
        logic        ok;
        for (int i = 0; i < 4; i++) begin
            y = $urandom_range(1583, 9999);
            m = $urandom_range(1, 12);
            d = $urandom_range(1, 28);
            run_date(y, m, d, 1'b0, res, ctrl, cyc, ok);
            checks++;
            if (!ok || res !== 16'(ref_dow(y, m, d))) begin
                errors++;
                $display("FAIL b2b %0d-%0d-%0d: got %0d, want %0d", y, m, d, res, ref_dow(y, m, d));
            end
        end
    endtask

    task automatic test_irq();
        logic [15:0] res, ctrl;
        int          cyc;
        logic        ok;
        run_date(2024, 2, 29, 1'b1, res, ctrl, cyc, ok);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_at_done: got %b, want 0", irq); end
        @(posedge clk); #1;
`ifdef DOW_IRQ_EN
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b, want 1", irq); end
        bus_wr(3'd3, 16'h0006);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b, want 1", irq); end
        @(posedge clk); #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b, want 0", irq); end
`else
        checks++; if (irq !== 1'b0 || ctrl[1] !== 1'b0) begin errors++; $display("FAIL irq_off: got irq %b ctrl %0h, want 0", irq, ctrl); end
`endif
    endtask

    initial begin
        reset     = 1'b1;
        write     = 1'b0;
        read      = 1'b0;
        address   = '0;
        writedata = '0;
        #12;
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        test_regs();
        test_directed();
        test_random();
        test_busy_protect();
        test_w1c();
        test_reset_midop();
        test_back_to_back();
        test_irq();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/day_of_week_calc.md
# day_of_week_calc

Memory-mapped calendar coprocessor for the Nios II system bus that computes the Gregorian day of week for any date in a parametrised year range. It is the multi-cycle, range-generalised successor to the combinational 1900–2019 day lookup. It uses a bit-serial divide-by-100 and a bit-serial mod-7 reducer instead of decade tables. It validates the date before computing, including leap years, days per month and year range. It reports busy/done/error status and can raise an optional interrupt.

## Interface
- `DATA_W`, 16: bus data width; `YEAR_W` <= `DATA_W`.
- `YEAR_W`, 14: year register width; `MAX_YEAR` < 2^`YEAR_W`.
- `MIN_YEAR`, 1583: lowest accepted year.
- `MAX_YEAR`, 9999: highest accepted year.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `address`  in  3  register select.
- `write`  in  1  write strobe, one cycle per access.
- `writedata`  in  `DATA_W`  write data.
- `read`  in  1  read strobe.
- `readdata`  out  `DATA_W`  combinational read data; 0 when `read`=0 or the address is unmapped.
- `irq`  out  1  interrupt request; level, registered.

## Operation
- Register map:
  - 0 YEAR: RW, `YEAR_W` bits.
  - 1 MONTH: RW, 4 bits.
  - 2 DATE: RW, 5 bits.
  - 3 CTRL. Write: bit0 start (self-clearing), bit1 irq_en, bit2 W1C done. Read: bit0 busy, bit1 irq_en, bit2 done, bit3 error.
  - 4 RESULT: RO, bits[2:0]. Values 0=Sunday..6=Saturday; 7=invalid.
  - Unmapped bits and addresses read 0.
- Writes to YEAR/MONTH/DATE while busy are ignored. Start while busy is ignored. irq_en is always writable.
- Start with busy=0: latch the operands, clear done and error, set busy, and enter DIV.
- FSM states: IDLE -> DIV -> CHECK -> MOD -> IDLE.
  - DIV: restoring division of YEAR by 100 over `YEAR_W` cycles, giving q=Y/100 and r=Y%100.
  - CHECK, 1 cycle: leap = (Y[1:0]==0) && (r!=0 || q[1:0]==0).
    - Valid iff `MIN_YEAR`<=Y<=`MAX_YEAR`, 1<=M<=12, and 1<=D<=dim(M,leap).
    - Invalid: RESULT=7, error=1, done=1, busy=0, go to IDLE.
    - Valid: for M<3, Y'=Y-1, q'=q-(r==0); otherwise Y'=Y, q'=q.
    - S = Y' + (Y'>>2) - q' + (q'>>2) + t[M] + D, where t = {0,3,2,5,0,3,5,1,4,6,2,4}. S is `YEAR_W`+1 bits and never negative.
  - MOD: restoring reduction of S mod 7 over `YEAR_W`+1 cycles, MSB first. On the last cycle: RESULT=remainder, done=1, busy=0, go to IDLE.
- RESULT holds its value until the next completion. Reset value of RESULT is 0.
- A done W1C and a completion in the same cycle: completion wins, so done=1.
- A start in the same cycle as a done W1C while idle: start wins.

## Timing
- Start is accepted at clock edge N, and busy reads 1 after edge N.
- Valid date: done, RESULT and busy=0 are visible after edge N+2·`YEAR_W`+2 (30 cycles at defaults).
- Invalid date: done, error and busy=0 are visible after edge N+`YEAR_W`+1 (15 cycles at defaults).
- `readdata` is valid in the same cycle as `read`, with no wait states.
- `irq` updates on the edge after done or irq_en changes.
- Reset, asynchronous and at any time including mid-operation:
  - All registers go to 0, FSM goes to IDLE, busy/done/error=0, `irq`=0.
  - Any computation in flight is discarded.

## Configuration
- `DOW_IRQ_EN` defined: `irq` = registered (done & irq_en), and CTRL bit1 is RW.
- `DOW_IRQ_EN` undefined: `irq` is tied to 0, CTRL bit1 writes are ignored and read 0, and no irq flop is built.

## Test plan
- 2024-02-29 -> after 30 cycles RESULT=4 (Thursday), error=0, busy=0.
- 2023-02-29 -> after 15 cycles RESULT=7, error=1. Also 1900-02-29 -> RESULT=7 (century non-leap).
- 2000-01-01 -> RESULT=6. 2000-02-29 -> RESULT=2 (400-year leap, M<3 adjustment with r==0).
- Range and fields:
  - Year 1582 -> error. Year 9999-12-31 -> RESULT=5.
  - Month 0, month 13 and date 0 -> error.
- Busy protection:
  - Start, then write YEAR=1999 and a second start at cycle 5.
  - The first result is unaffected, and the YEAR read-back still shows the original value.
- Reset at cycle 10 of a computation:
  - All reads return 0 and `irq`=0.
  - A new start afterwards computes correctly.
  - With `DOW_IRQ_EN`, irq_en=1: `irq` rises one cycle after done, and falls one cycle after a W1C to done.
